// File: rtl/camera_capture_rgb565_if.sv
// Camera byte stream in, assembled RGB565 pixel stream out.
// The capture block is the master: it samples the camera side and drives the pixel side.
interface camera_capture_rgb565_if;
  // Camera side (OV7670 pins, sampled as data in the system clock domain)
  logic       PCLK;
  logic       VSYNC;
  logic       HREF;
  logic [7:0] D;

  // Pixel side (towards the colour-filter/accumulator stage)
  logic [4:0] RED;
  logic [5:0] GREEN;
  logic [4:0] BLUE;
  logic [8:0] PIXEL_ROW;
  logic [9:0] PIXEL_COLUMN;
  logic       READY_COLOR;
  logic       FRAME_DONE;

  modport master (
    input  PCLK, VSYNC, HREF, D,
    output RED, GREEN, BLUE, PIXEL_ROW, PIXEL_COLUMN, READY_COLOR, FRAME_DONE
  );

  modport slave (
    output PCLK, VSYNC, HREF, D,
    input  RED, GREEN, BLUE, PIXEL_ROW, PIXEL_COLUMN, READY_COLOR, FRAME_DONE
  );
endinterface

// File: rtl/camera_capture_rgb565.sv
// OV7670 capture front end: oversamples PCLK/HREF/VSYNC/D in the CLK domain,
// pairs bytes into RGB565 pixels, tags them with row/column and strobes
// READY_COLOR once per pixel. FRAME_DONE marks the last pixel of a frame.
module camera_capture_rgb565 #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input logic                    CLK,
  input logic                    RST_N,
  camera_capture_rgb565_if.master cam
);

  localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM  = 9'(V_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0] V_LAST = 9'(V_ACTIVE - 1);

  typedef enum logic {
    ST_FIRST,
    ST_SECOND
  } state_t;

  // Synchronizer stages
  logic       pclk_meta_q, pclk_sync_q, pclk_prev_q;
  logic       href_meta_q, href_sync_q, href_prev_q;
  logic       vsync_meta_q, vsync_sync_q;
  logic [7:0] d_meta_q, d_sync_q;

  // Capture state
  state_t     state_q, state_d;
  logic [7:0] hi_q, hi_d;
  logic [8:0] line_q, line_d;
  logic [9:0] col_q, col_d;

  // Output registers
  logic [4:0] red_q, red_d;
  logic [5:0] green_q, green_d;
  logic [4:0] blue_q, blue_d;
  logic [8:0] row_o_q, row_o_d;
  logic [9:0] col_o_q, col_o_d;
  logic       ready_q, ready_d;
  logic       done_q, done_d;

  logic pclk_rise;
  logic href_fall;
  logic emit;

  assign pclk_rise = pclk_sync_q & ~pclk_prev_q;
  assign href_fall = href_prev_q & ~href_sync_q;

  // Two-flop synchronizers plus edge-detect history for PCLK and HREF
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pclk_meta_q  <= 1'b0;
      pclk_sync_q  <= 1'b0;
      pclk_prev_q  <= 1'b0;
      href_meta_q  <= 1'b0;
      href_sync_q  <= 1'b0;
      href_prev_q  <= 1'b0;
      vsync_meta_q <= 1'b0;
      vsync_sync_q <= 1'b0;
      d_meta_q     <= '0;
      d_sync_q     <= '0;
    end else begin
      pclk_meta_q  <= cam.PCLK;
      pclk_sync_q  <= pclk_meta_q;
      pclk_prev_q  <= pclk_sync_q;
      href_meta_q  <= cam.HREF;
      href_sync_q  <= href_meta_q;
      href_prev_q  <= href_sync_q;
      vsync_meta_q <= cam.VSYNC;
      vsync_sync_q <= vsync_meta_q;
      d_meta_q     <= cam.D;
      d_sync_q     <= d_meta_q;
    end
  end

  // Byte-pair FSM, line/column tracking and pixel emit decision
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    line_d  = line_q;
    col_d   = col_q;
    emit    = 1'b0;

    if (vsync_sync_q || !href_sync_q) begin
      state_d = ST_FIRST;
    end else if (pclk_rise) begin
      unique case (state_q)
        ST_FIRST: begin
          hi_d    = d_sync_q;
          state_d = ST_SECOND;
        end
        ST_SECOND: begin
          state_d = ST_FIRST;
          emit    = (line_q < V_LIM) && (col_q < H_LIM);
        end
        default: state_d = ST_FIRST;
      endcase
    end

    // VSYNC overrides everything, including an emit in the same cycle
    if (vsync_sync_q) begin
      line_d = '0;
      col_d  = '0;
    end else if (emit) begin
      col_d = col_q + 10'd1;
    end else if (href_fall && (col_q != '0)) begin
      line_d = (line_q < V_LIM) ? line_q + 9'd1 : line_q;
      col_d  = '0;
    end
  end

  // Output staging: hold last pixel, strobe on emit
  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    row_o_d = row_o_q;
    col_o_d = col_o_q;
    ready_d = 1'b0;
    done_d  = 1'b0;
    if (emit && !vsync_sync_q) begin
      red_d   = hi_q[7:3];
      green_d = {hi_q[2:0], d_sync_q[7:5]};
      blue_d  = d_sync_q[4:0];
      row_o_d = line_q;
      col_o_d = col_q;
      ready_d = 1'b1;
      done_d  = (line_q == V_LAST) && (col_q == H_LAST);
    end
  end

  // Capture state and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_FIRST;
      hi_q    <= '0;
      line_q  <= '0;
      col_q   <= '0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      row_o_q <= '0;
      col_o_q <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      line_q  <= line_d;
      col_q   <= col_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      row_o_q <= row_o_d;
      col_o_q <= col_o_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign cam.RED          = red_q;
  assign cam.GREEN        = green_q;
  assign cam.BLUE         = blue_q;
  assign cam.PIXEL_ROW    = row_o_q;
  assign cam.PIXEL_COLUMN = col_o_q;
  assign cam.READY_COLOR  = ready_q;
  assign cam.FRAME_DONE   = done_q;

endmodule

// File: tb/tb_camera_capture_rgb565.sv
// Directed bench for camera_capture_rgb565 with a reduced frame size.
module tb_camera_capture_rgb565;

  localparam int unsigned H = 4;
  localparam int unsigned V = 3;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    logic [8:0] row;
    logic [9:0] col;
    logic       fd;
  } pix_t;

  logic CLK;
  logic RST_N;
  camera_capture_rgb565_if bus ();

  camera_capture_rgb565 #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .cam  (bus.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  pix_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  logic prev_ready = 1'b0;

  // Monitor: every strobe pops one expected pixel
  always @(negedge CLK) begin
    pix_t obs;
    pix_t expv;
    obs = {bus.RED, bus.GREEN, bus.BLUE, bus.PIXEL_ROW, bus.PIXEL_COLUMN, bus.FRAME_DONE};
    if (bus.READY_COLOR) begin
      compared++;
      assert (exp_q.size() > 0) else begin
        mismatched++;
        $error("FAIL unexpected_strobe observed=%h expected=<none>", obs);
      end
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        compared++;
        assert (obs === expv) else begin
          mismatched++;
          $error("FAIL pixel observed r=%0d g=%0d b=%0d row=%0d col=%0d fd=%0d expected r=%0d g=%0d b=%0d row=%0d col=%0d fd=%0d",
                 obs.r, obs.g, obs.b, obs.row, obs.col, obs.fd,
                 expv.r, expv.g, expv.b, expv.row, expv.col, expv.fd);
        end
      end
      compared++;
      assert (prev_ready === 1'b0) else begin
        mismatched++;
        $error("FAIL strobe_width observed=high_two_cycles expected=one_cycle");
      end
    end else if (bus.FRAME_DONE) begin
      compared++;
      assert (bus.FRAME_DONE === 1'b0) else begin
        mismatched++;
        $error("FAIL frame_done_alone observed=%b expected=0", bus.FRAME_DONE);
      end
    end
    prev_ready = bus.READY_COLOR;
  end

  task automatic push_exp(input logic [4:0] r, input logic [5:0] g, input logic [4:0] b,
                          input int unsigned row, input int unsigned col);
    pix_t p;
    p.r   = r;
    p.g   = g;
    p.b   = b;
    p.row = 9'(row);
    p.col = 10'(col);
    p.fd  = (row == V - 1) && (col == H - 1);
    exp_q.push_back(p);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    bus.PCLK = 1'b0;
    bus.D    = b;
    repeat (3) @(negedge CLK);
    bus.PCLK = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo, input bit expect_it,
                            input int unsigned row, input int unsigned col);
    if (expect_it) push_exp(hi[7:3], {hi[2:0], lo[7:5]}, lo[4:0], row, col);
    send_byte(hi);
    send_byte(lo);
  endtask

  task automatic start_line();
    @(negedge CLK);
    bus.HREF = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  task automatic end_line();
    @(negedge CLK);
    bus.PCLK = 1'b0;
    bus.HREF = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic vsync_pulse();
    @(negedge CLK);
    bus.VSYNC = 1'b1;
    repeat (4) @(negedge CLK);
    bus.VSYNC = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge CLK);
    compared++;
    assert (exp_q.size() == 0) else begin
      mismatched++;
      $error("FAIL drain_%s observed_pending=%0d expected_pending=0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [41:0] o;
    o = {bus.RED, bus.GREEN, bus.BLUE, bus.PIXEL_ROW, bus.PIXEL_COLUMN, bus.READY_COLOR, bus.FRAME_DONE};
    compared++;
    assert (o === '0) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=0", tag, o);
    end
  endtask

  initial begin
    RST_N     = 1'b0;
    bus.PCLK  = 1'b0;
    bus.VSYNC = 1'b0;
    bus.HREF  = 1'b0;
    bus.D     = '0;

    // Reset held while camera inputs toggle
    for (int i = 0; i < 24; i++) begin
      @(negedge CLK);
      bus.PCLK = ~bus.PCLK;
      bus.HREF = (i % 6) < 4;
      bus.D    = 8'($urandom);
    end
    check_outputs_zero("in_reset");
    @(negedge CLK);
    bus.PCLK = 1'b0;
    bus.HREF = 1'b0;
    bus.D    = '0;
    RST_N    = 1'b1;
    repeat (6) @(negedge CLK);
    check_outputs_zero("after_reset");

    // Single line: pure red then pure green
    vsync_pulse();
    start_line();
    push_exp(5'd31, 6'd0, 5'd0, 0, 0);
    send_byte(8'hF8);
    send_byte(8'h00);
    push_exp(5'd0, 6'd63, 5'd0, 0, 1);
    send_byte(8'h07);
    send_byte(8'hE0);
    end_line();
    drain("single_line");

    // Full frame, pixel value = column
    vsync_pulse();
    for (int r = 0; r < V; r++) begin
      start_line();
      for (int c = 0; c < H; c++) send_pixel(8'h00, 8'(c), 1'b1, r, c);
      end_line();
    end
    drain("full_frame");

    // Overlong lines and an extra line: surplus must not strobe
    vsync_pulse();
    for (int r = 0; r <= V; r++) begin
      start_line();
      for (int c = 0; c < H + 2; c++)
        send_pixel(8'(16 * r + c + 8'h21), 8'(8'hC3 ^ (c * 7)), (r < V) && (c < H), r, c);
      end_line();
    end
    drain("overlong");
    vsync_pulse();
    start_line();
    send_pixel(8'h9A, 8'hBC, 1'b1, 0, 0);
    end_line();
    drain("after_overlong");

    // Odd byte count: third byte dropped, next line assembles cleanly
    vsync_pulse();
    start_line();
    send_pixel(8'hA5, 8'h5A, 1'b1, 0, 0);
    send_byte(8'hFF);
    end_line();
    start_line();
    send_pixel(8'h12, 8'h34, 1'b1, 1, 0);
    send_pixel(8'h56, 8'h78, 1'b1, 1, 1);
    end_line();
    drain("odd_bytes");

    // Asynchronous reset mid-line
    vsync_pulse();
    start_line();
    send_pixel(8'hC3, 8'h3C, 1'b1, 0, 0);
    send_pixel(8'h81, 8'h18, 1'b1, 0, 1);
    drain("pre_reset");
    send_byte(8'h77);
    @(negedge CLK);
    #1 RST_N = 1'b0;
    #1 check_outputs_zero("async_reset");
    bus.PCLK = 1'b0;
    bus.HREF = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);

    // VSYNC abort mid-line, then a fresh frame starts at row 0, col 0
    start_line();
    send_pixel(8'h11, 8'h22, 1'b1, 0, 0);
    send_byte(8'h33);
    @(negedge CLK);
    bus.VSYNC = 1'b1;
    repeat (4) @(negedge CLK);
    bus.PCLK = 1'b0;
    bus.HREF = 1'b0;
    repeat (2) @(negedge CLK);
    bus.VSYNC = 1'b0;
    repeat (4) @(negedge CLK);
    start_line();
    send_pixel(8'h44, 8'h55, 1'b1, 0, 0);
    send_pixel(8'h66, 8'h77, 1'b1, 0, 1);
    end_line();
    drain("vsync_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
